// File: rtl/i2c_target.sv
// I2C target exposing an NREGS-byte register file: pointer-then-data writes, auto-incrementing reads.
// Latency: 3 HCLK from an SCL/SDA pin edge to the internal reaction; host peek is combinational.
// Backpressure: none; the bus master paces every transfer and wr_stb is a fire-and-forget pulse.
//
// Ports:
//   HCLK, HRESET      system clock (>= 16x SCL) and asynchronous active-high reset
//   scl_i, sda_i      asynchronous pad inputs
//   sda_oe            1 = pull SDA low (open-drain pad)
//   wr_stb/addr/data  one-HCLK pulse per byte written from the bus, with index and value
//   host_addr/rdata   combinational peek into the register file
//   busy              set from an addressed START until STOP / return to IDLE
module i2c_target #(
  parameter logic [6:0] ADDR  = 7'h42,
  parameter int         NREGS = 16,
  parameter int         AW    = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P, S_WDATA, S_ACK_W, S_RDATA, S_MACK
  } state_e;

  // Synchronizers plus history, all idle-high so reset never looks like an edge.
  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_e        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NREGS];

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  logic [7:0] rdata;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  assign scl_rise  =  scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q &  scl_hist_q;
  assign sda_rise  =  sda_sync_q & ~sda_hist_q;
  assign sda_fall  = ~sda_sync_q &  sda_hist_q;
  assign start_det = sda_fall & scl_sync_q;
  assign stop_det  = sda_rise & scl_sync_q;

  assign rdata = regs_q[ptr_q];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      sh_q      <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // The array commits from the strobe registers, so a peek of the same index
  // shows the new byte the cycle after wr_stb.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else if (wr_stb_q) begin
      regs_q[wr_addr_q] <= wr_data_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            sh_d      = {sh_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            // Byte complete: the falling edge that ends bit 8 opens the ACK slot.
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            case (state_q)
              S_ADDR: begin
                if (sh_q[7:1] == ADDR) begin
                  state_d = S_ACK_A;
                end else begin
                  state_d  = S_IDLE;
                  sda_oe_d = 1'b0;
                end
              end
              S_PTR: begin
                ptr_d   = sh_q[AW-1:0];
                state_d = S_ACK_P;
              end
              default: begin
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = sh_q;
                ptr_d     = ptr_q + AW'(1);
                state_d   = S_ACK_W;
              end
            endcase
          end
        end
        S_ACK_A: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (sh_q[0]) begin
              // Read: the ACK-ending fall also presents the first data bit.
              sh_d     = rdata;
              ptr_d    = ptr_q + AW'(1);
              sda_oe_d = ~rdata[7];
              state_d  = S_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_PTR;
            end
          end
        end
        S_ACK_P, S_ACK_W: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_MACK;
            end else begin
              // After k bits clocked, bit 7-k is due; 7-k == ~k in three bits.
              sda_oe_d = ~sh_q[~bit_cnt_q[2:0]];
            end
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            if (sda_sync_q) begin
              state_d = S_IDLE;
            end else begin
              sh_d      = rdata;
              ptr_d     = ptr_q + AW'(1);
              bit_cnt_d = 4'd0;
              state_d   = S_RDATA;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_IDLE)
      busy_d = 1'b0;
    else if (state_d == S_ACK_A && state_q != S_ACK_A)
      busy_d = 1'b1;
    else
      busy_d = busy_q;
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_addr, host_addr;
  logic [7:0] wr_data, host_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe/drive monitor: cumulative counters only; tests take deltas.
  int         stb_cnt = 0;
  int         stb_wide = 0;
  int         oe_cnt = 0;
  logic       prev_stb = 1'b0;
  logic [3:0] stb_addr [8];
  logic [7:0] stb_data [8];

  always #5 HCLK = ~HCLK;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target #(.ADDR(7'h42), .NREGS(16), .AW(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_addr(host_addr), .host_rdata(host_rdata), .busy(busy)
  );

  always @(negedge HCLK) begin
    if (wr_stb) begin
      stb_addr[stb_cnt % 8] = wr_addr;
      stb_data[stb_cnt % 8] = wr_data;
      stb_cnt++;
      if (prev_stb) stb_wide++;
    end
    prev_stb = wr_stb;
    if (sda_oe) oe_cnt++;
  end

  task automatic hclks(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; hclks(4); scl_m = 1'b1; hclks(8);
    end
    sda_m = 1'b0; hclks(8); scl_m = 1'b0; hclks(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hclks(3); scl_m = 1'b1; hclks(8); sda_m = 1'b1; hclks(8);
  endtask

  task automatic clock_bit(input logic b, output logic bus_v, output logic oe_v);
    sda_m = b; hclks(3);
    scl_m = 1'b1; hclks(4);
    bus_v = sda_bus; oe_v = sda_oe;
    hclks(4);
    scl_m = 1'b0; hclks(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic bv, ov;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], bv, ov);
    clock_bit(1'b1, bv, ov);
    acked = ov & ~bv;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic bv, ov;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, bv, ov);
      b[i] = bv;
    end
    clock_bit(mack, bv, ov);
  endtask

  task automatic test_reset();
    HRESET = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_addr = 4'd0;
    hclks(3);
    n_checks++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe_in_reset: got %b want 0", sda_oe); end
    HRESET = 1'b0;
    hclks(3);
    n_checks++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", sda_oe); end
    n_checks++;
    if (wr_stb !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_stb_busy: got %b/%b want 0/0", wr_stb, busy);
    end
    n_checks++;
    if (wr_addr !== 4'h0 || wr_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_wr_bus: got %h/%h want 0/00", wr_addr, wr_data);
    end
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i); hclks(1);
      n_checks++;
      if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 00", i, host_rdata); end
    end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int base = stb_cnt;
    int wide = stb_wide;
    i2c_start();
    send_byte(8'h84, a0);
    send_byte(8'h00, a1);
    send_byte(8'h45, a2);
    n_checks++;
    if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2}); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_mid: got %b want 1", busy); end
    i2c_stop();
    n_checks++;
    if (stb_cnt - base !== 1) begin n_fail++; $display("FAIL write_stb_count: got %0d want 1", stb_cnt - base); end
    n_checks++;
    if (stb_addr[base % 8] !== 4'h0 || stb_data[base % 8] !== 8'h45) begin
      n_fail++; $display("FAIL write_stb_payload: got %h/%h want 0/45", stb_addr[base % 8], stb_data[base % 8]);
    end
    n_checks++;
    if (stb_wide !== wide) begin n_fail++; $display("FAIL write_stb_width: got %0d multi-cycle pulses want 0", stb_wide - wide); end
    host_addr = 4'd0; hclks(1);
    n_checks++;
    if (host_rdata !== 8'd69) begin n_fail++; $display("FAIL write_peek0: got %h want 45", host_rdata); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_burst_wrap();
    logic a;
    logic [7:0] exp_d [3];
    logic [3:0] exp_a [3];
    int base = stb_cnt;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0;
    i2c_start();
    send_byte(8'h84, a);
    send_byte(8'h0E, a);
    for (int i = 0; i < 3; i++) send_byte(exp_d[i], a);
    n_checks++;
    if (a !== 1'b1) begin n_fail++; $display("FAIL burst_last_ack: got %b want 1", a); end
    i2c_stop();
    n_checks++;
    if (stb_cnt - base !== 3) begin n_fail++; $display("FAIL burst_stb_count: got %0d want 3", stb_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (stb_addr[(base + i) % 8] !== exp_a[i]) begin
        n_fail++; $display("FAIL burst_stb_addr%0d: got %h want %h", i, stb_addr[(base + i) % 8], exp_a[i]);
      end
      host_addr = exp_a[i]; hclks(1);
      n_checks++;
      if (host_rdata !== exp_d[i]) begin
        n_fail++; $display("FAIL burst_reg%0d: got %h want %h", exp_a[i], host_rdata, exp_d[i]);
      end
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1, b2;
    int base = stb_cnt;
    i2c_start();
    send_byte(8'h84, a0);
    send_byte(8'h0E, a1);
    i2c_start();
    send_byte(8'h85, a2);
    n_checks++;
    if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
    recv_byte(1'b0, b0);
    recv_byte(1'b0, b1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy_mid: got %b want 1", busy); end
    recv_byte(1'b1, b2);
    n_checks++;
    if (b0 !== 8'h11 || b1 !== 8'h22 || b2 !== 8'h33) begin
      n_fail++; $display("FAIL read_bytes: got %h %h %h want 11 22 33", b0, b1, b2);
    end
    n_checks++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nack: got %b want 0", sda_oe); end
    i2c_stop();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_after_stop: got %b want 0", busy); end
    n_checks++;
    if (stb_cnt !== base) begin n_fail++; $display("FAIL read_no_stb: got %0d strobes want 0", stb_cnt - base); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int base = stb_cnt;
    int oe0 = oe_cnt;
    i2c_start();
    send_byte(8'h86, a0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy: got %b want 0", busy); end
    send_byte(8'hFF, a1);
    i2c_stop();
    n_checks++;
    if (oe_cnt !== oe0 || a0 !== 1'b0 || a1 !== 1'b0) begin
      n_fail++; $display("FAIL mismatch_sda_driven: got %0d driven cycles want 0", oe_cnt - oe0);
    end
    n_checks++;
    if (stb_cnt !== base) begin n_fail++; $display("FAIL mismatch_stb: got %0d strobes want 0", stb_cnt - base); end
    host_addr = 4'd14; hclks(1);
    n_checks++;
    if (host_rdata !== 8'h11) begin n_fail++; $display("FAIL mismatch_reg14: got %h want 11", host_rdata); end
    host_addr = 4'd15; hclks(1);
    n_checks++;
    if (host_rdata !== 8'h22) begin n_fail++; $display("FAIL mismatch_reg15: got %h want 22", host_rdata); end
  endtask

  task automatic test_stop_mid_byte();
    logic a, bv, ov;
    int base = stb_cnt;
    i2c_start();
    send_byte(8'h84, a);
    send_byte(8'h03, a);
    clock_bit(1'b1, bv, ov);
    clock_bit(1'b0, bv, ov);
    clock_bit(1'b1, bv, ov);
    clock_bit(1'b0, bv, ov);
    i2c_stop();
    n_checks++;
    if (stb_cnt !== base) begin n_fail++; $display("FAIL stopmid_stb: got %0d strobes want 0", stb_cnt - base); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stopmid_busy: got %b want 0", busy); end
    host_addr = 4'd3; hclks(1);
    n_checks++;
    if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL stopmid_reg3: got %h want 00", host_rdata); end
    i2c_start();
    send_byte(8'h84, a);
    send_byte(8'h05, a);
    send_byte(8'hA5, a);
    i2c_stop();
    n_checks++;
    if (stb_cnt - base !== 1 || stb_addr[base % 8] !== 4'd5 || stb_data[base % 8] !== 8'hA5) begin
      n_fail++; $display("FAIL stopmid_next_write: got %0d strobes %h/%h want 1 5/a5",
                         stb_cnt - base, stb_addr[base % 8], stb_data[base % 8]);
    end
    host_addr = 4'd5; hclks(1);
    n_checks++;
    if (host_rdata !== 8'hA5) begin n_fail++; $display("FAIL stopmid_reg5: got %h want a5", host_rdata); end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    i2c_start();
    send_byte(8'h84, a);
    send_byte(8'h00, a);
    i2c_start();
    send_byte(8'h85, a);
    // Register 0 holds 0x33, so its MSB (0) is being driven low now.
    n_checks++;
    if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_precond_oe: got %b want 1", sda_oe); end
    HRESET = 1'b1;
    #1;
    n_checks++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_release: got %b want 0", sda_oe); end
    scl_m = 1'b1; sda_m = 1'b1;
    hclks(3);
    HRESET = 1'b0;
    hclks(3);
    n_checks++;
    if (busy !== 1'b0 || wr_stb !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_busy_stb: got %b/%b want 0/0", busy, wr_stb);
    end
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i); hclks(1);
      n_checks++;
      if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_reg%0d: got %h want 00", i, host_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_wrap();
    test_read();
    test_mismatch();
    test_stop_mid_byte();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
